// File: rtl/seg7_scan_reader_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner:
// FSM states, digit-byte field positions and the hex glyph table.
`timescale 1ns/1ps
package seg7_scan_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int VALUE_LSB = 0;
    localparam int VALUE_W   = 4;
    localparam int BLANK_BIT = 4;
    localparam int DP_BIT    = 7;
    localparam int LANE_W    = 8;

    // Active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_reader_decode.sv
// Combinational digit decode: {blank, hex value} -> active-high segments.
`timescale 1ns/1ps
module seg7_scan_reader_decode
    import seg7_scan_reader_pkg::*;
(
    input  logic       blank,
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? 7'h00 : hex_glyph(value);
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Multiplexed 7-segment driver: fetches one digit byte per scan slot from
// RAM port B, decodes it and drives time-multiplexed anodes with a dark gap.
`timescale 1ns/1ps
module seg7_scan_reader
    import seg7_scan_reader_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 5,
    parameter int BASE_ADDR      = 0,
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IW = $clog2(NUM_DIGITS)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    output logic [ADDRESS_WIDTH-1:0] addrb,
    output logic                     renb,
    input  logic [31:0]              doutb,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic [NUM_DIGITS-1:0]    an,
    output logic [IW-1:0]            digit_idx,
    output logic                     frame_tick
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [IW-1:0]         LAST    = IW'(NUM_DIGITS - 1);

    state_t                state, state_d;
    logic [PW-1:0]         presc;
    logic                  tick;
    logic [IW-1:0]         nxt_idx, nxt_d;
    logic [AW-1:0]         idx_ext, word_addr;
    logic [1:0]            lane;
    logic [4:0]            lane_low;
    logic                  lane_dp;
    logic [6:0]            seg_hi, seg_lit;
    logic [NUM_DIGITS-1:0] onehot, an_lit;

    logic [AW-1:0]         addrb_d;
    logic                  renb_d, dp_d, ft_d;
    logic [6:0]            seg_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [IW-1:0]         idx_d;

    // Free-running slot timer; parked at zero while disabled so re-enable waits a full slot
    assign tick = enable && (presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              presc <= '0;
        else if (!enable || tick) presc <= '0;
        else                      presc <= presc + 1'b1;
    end

    // Digit idx lives in byte lane idx%4 of the word at BASE_ADDR + 4*(idx/4)
    assign idx_ext   = AW'(nxt_idx);
    assign word_addr = AW'(BASE_ADDR) + (idx_ext & ~AW'(3));
    assign lane      = nxt_idx[1:0];
    assign lane_low  = doutb[LANE_W*lane +: 5];
    assign lane_dp   = doutb[LANE_W*lane + DP_BIT];

    seg7_scan_reader_decode u_decode (
        .blank (lane_low[BLANK_BIT]),
        .value (lane_low[VALUE_LSB +: VALUE_W]),
        .seg   (seg_hi)
    );

    assign seg_lit = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    assign onehot  = NUM_DIGITS'(1) << nxt_idx;
    assign an_lit  = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;

    always_comb begin
        state_d = state;
        renb_d  = 1'b0;
        addrb_d = addrb;
        seg_d   = seg;
        dp_d    = dp;
        an_d    = an;
        idx_d   = digit_idx;
        nxt_d   = nxt_idx;
        ft_d    = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_d = FETCH;
                    renb_d  = 1'b1;
                    addrb_d = word_addr;
                    an_d    = AN_OFF;
                end else if (!enable) begin
                    seg_d = SEG_OFF;
                    dp_d  = DP_OFF;
                    an_d  = AN_OFF;
                end
            end
            FETCH: begin
                state_d = LATCH;
                an_d    = AN_OFF;
            end
            LATCH: begin
                // The read always completes; a disable only keeps the display dark
                state_d = IDLE;
                idx_d   = nxt_idx;
                nxt_d   = (nxt_idx == LAST) ? '0 : nxt_idx + 1'b1;
                ft_d    = (nxt_idx == LAST);
                if (enable) begin
                    seg_d = seg_lit;
                    dp_d  = lane_dp ? ~DP_OFF : DP_OFF;
                    an_d  = an_lit;
                end else begin
                    seg_d = SEG_OFF;
                    dp_d  = DP_OFF;
                    an_d  = AN_OFF;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            nxt_idx    <= '0;
            renb       <= 1'b0;
            addrb      <= '0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_d;
            nxt_idx    <= nxt_d;
            renb       <= renb_d;
            addrb      <= addrb_d;
            seg        <= seg_d;
            dp         <= dp_d;
            an         <= an_d;
            digit_idx  <= idx_d;
            frame_tick <= ft_d;
        end
    end

endmodule
